// File: rtl/fetch_pc_unit_pkg.sv
// Package cpu_defs: definitions shared by the P5 fetch stage.
//   npc_sel_e    - redirect kind of the instruction held in decode
//   RESET_PC_C   - address of the first instruction (ROM base)
//   NOP          - instruction word injected for an erroring fetch
//   sext16       - sign extension helper for 16-bit immediates
package cpu_defs;

    typedef enum logic [1:0] {
        NPC_SEQ = 2'b00,
        NPC_BR  = 2'b01,
        NPC_J   = 2'b10,
        NPC_JR  = 2'b11
    } npc_sel_e;

    localparam logic [31:0] RESET_PC_C = 32'h0000_3000;
    localparam logic [31:0] NOP        = 32'h0000_0000;

    function automatic logic signed [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch/decode bus of the P5 core.
//   master : the fetch unit (drives pcF, addr_errF, pcD, instrD, pc8D)
//   slave  : the surrounding pipeline, ROM and hazard unit
// Signals:
//   stall                         - hazard-unit freeze
//   instrF                        - ROM data for pcF
//   npc_selD/br_takenD/imm16D/idx26D/rsdataD - decode-stage redirect info
//   pcF/addr_errF                 - fetch address and its fault flag
//   pcD/instrD/pc8D               - F/D register contents and jal link value
interface fetch_pc_unit_if;

    logic        stall;
    logic [31:0] instrF;
    logic [1:0]  npc_selD;
    logic        br_takenD;
    logic [15:0] imm16D;
    logic [25:0] idx26D;
    logic [31:0] rsdataD;
    logic [31:0] pcF;
    logic        addr_errF;
    logic [31:0] pcD;
    logic [31:0] instrD;
    logic [31:0] pc8D;

    modport master (
        input  stall, instrF, npc_selD, br_takenD, imm16D, idx26D, rsdataD,
        output pcF, addr_errF, pcD, instrD, pc8D
    );

    modport slave (
        output stall, instrF, npc_selD, br_takenD, imm16D, idx26D, rsdataD,
        input  pcF, addr_errF, pcD, instrD, pc8D
    );

endinterface

// File: rtl/fetch_pc_unit_npc.sv
// npc_calc: combinational next-PC selection.
//   pcF, pcD                 - current fetch PC and PC of the instruction in D
//   npc_sel, br_taken        - redirect kind and branch outcome
//   imm16, idx26, rsdata     - branch offset, jump index, jr target
//   npc                      - address loaded into pcF on the next edge
// The branch target is relative to the delay slot (pcD+4), which is why
// pcD rather than pcF is used for branches and jumps.
module npc_calc
    import cpu_defs::*;
(
    input  logic [31:0] pcF,
    input  logic [31:0] pcD,
    input  logic [1:0]  npc_sel,
    input  logic        br_taken,
    input  logic [15:0] imm16,
    input  logic [25:0] idx26,
    input  logic [31:0] rsdata,
    output logic [31:0] npc
);

    logic signed [31:0] br_off;
    logic [31:0]        seq_pc;
    logic [31:0]        br_pc;
    logic [31:0]        j_pc;

    // Sign-extend first, then scale to bytes: 16'hFFFF becomes -4.
    assign br_off = sext16(imm16) <<< 2;
    assign seq_pc = pcF + 32'd4;
    assign br_pc  = pcD + 32'd4 + br_off;
    assign j_pc   = {pcD[31:28], idx26, 2'b00};

    always_comb begin
        npc = seq_pc;
        unique case (npc_sel_e'(npc_sel))
            NPC_SEQ: npc = seq_pc;
            NPC_BR:  npc = br_taken ? br_pc : seq_pc;
            NPC_J:   npc = j_pc;
            NPC_JR:  npc = rsdata;
            default: npc = seq_pc;
        endcase
    end

endmodule

// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: P5 fetch-stage program counter and F/D pipeline register.
//   clk    - system clock, rising edge
//   reset  - synchronous active-high reset (wins over stall)
//   bus    - fetch/decode bus (master side), see fetch_pc_unit_if
// A redirect resolved in D is loaded into pcF on the same edge that moves
// the delay slot into D; nothing is ever squashed. Stall freezes all three
// registers, so a stalled redirect is simply re-evaluated next cycle.
module fetch_pc_unit #(
    parameter logic [31:0] RESET_PC = cpu_defs::RESET_PC_C,
    parameter int          IM_WORDS = 4096
) (
    input  logic             clk,
    input  logic             reset,
    fetch_pc_unit_if.master  bus
);
    import cpu_defs::*;

    // Window bounds held in 33 bits so a ROM ending at 2^32 cannot wrap.
    localparam logic [32:0] ROM_LO = {1'b0, RESET_PC};
    localparam logic [32:0] ROM_HI = ROM_LO + (33'(IM_WORDS) << 2);

    logic [31:0] pcf_q;
    logic [31:0] pcd_q;
    logic [31:0] instrd_q;
    logic [31:0] npc;
    logic        addr_err;

    npc_calc u_npc (
        .pcF      (pcf_q),
        .pcD      (pcd_q),
        .npc_sel  (bus.npc_selD),
        .br_taken (bus.br_takenD),
        .imm16    (bus.imm16D),
        .idx26    (bus.idx26D),
        .rsdata   (bus.rsdataD),
        .npc      (npc)
    );

    assign addr_err = (pcf_q[1:0] != 2'b00)
                   || ({1'b0, pcf_q} <  ROM_LO)
                   || ({1'b0, pcf_q} >= ROM_HI);

    // F -> D stage boundary
    always_ff @(posedge clk) begin
        if (reset) begin
            pcf_q    <= RESET_PC;
            pcd_q    <= 32'h0;
            instrd_q <= NOP;
        end else if (!bus.stall) begin
            pcf_q    <= npc;
            pcd_q    <= pcf_q;
            // A faulting fetch still records its PC but carries a nop.
            instrd_q <= addr_err ? NOP : bus.instrF;
        end
    end

    assign bus.pcF       = pcf_q;
    assign bus.addr_errF = addr_err;
    assign bus.pcD       = pcd_q;
    assign bus.instrD    = instrd_q;
    assign bus.pc8D      = pcd_q + 32'd8;

endmodule

// File: tb/tb_fetch_pc_unit.sv
module tb_fetch_pc_unit;

    typedef struct {
        string       name;
        logic [31:0] pcf;
        logic [31:0] pcd;
        logic [31:0] instrd;
        logic [31:0] pc8d;
        logic        err;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    exp_t sb[$];
    exp_t mon_e;

    fetch_pc_unit_if bus ();

    fetch_pc_unit #(.RESET_PC(32'h0000_3000), .IM_WORDS(4096)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ROM model: tag each word with the low half of its address.
    assign bus.instrF = 32'hAB00_0000 | {16'h0, bus.pcF[15:0]};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: outputs are registered, so every cycle presents a new state.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_e = sb.pop_front();
            cmp({mon_e.name, ".pcF"},    bus.pcF,    mon_e.pcf);
            cmp({mon_e.name, ".pcD"},    bus.pcD,    mon_e.pcd);
            cmp({mon_e.name, ".instrD"}, bus.instrD, mon_e.instrd);
            cmp({mon_e.name, ".pc8D"},   bus.pc8D,   mon_e.pc8d);
            cmp({mon_e.name, ".addr_errF"}, {31'h0, bus.addr_errF}, {31'h0, mon_e.err});
        end
    end

    task automatic step(input string nm, input logic rst, input logic stl,
                        input logic [1:0] sel, input logic tk,
                        input logic [15:0] imm, input logic [25:0] idx,
                        input logic [31:0] rs,
                        input logic [31:0] e_pcf, input logic [31:0] e_pcd,
                        input logic [31:0] e_ins, input logic [31:0] e_pc8,
                        input logic e_err);
        exp_t e;
        reset         = rst;
        bus.stall     = stl;
        bus.npc_selD  = sel;
        bus.br_takenD = tk;
        bus.imm16D    = imm;
        bus.idx26D    = idx;
        bus.rsdataD   = rs;
        @(posedge clk);
        #1;
        e.name = nm; e.pcf = e_pcf; e.pcd = e_pcd;
        e.instrd = e_ins; e.pc8d = e_pc8; e.err = e_err;
        sb.push_back(e);
    endtask

    task automatic reset_and_run3();
        step("reset", 1, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3000, 32'h0, 32'h0, 32'h8, 0);
        step("seq1", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3004, 32'h3000, 32'hAB003000, 32'h3008, 0);
        step("seq2", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3008, 32'h3004, 32'hAB003004, 32'h300C, 0);
        step("seq3", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h300C, 32'h3008, 32'hAB003008, 32'h3010, 0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        bus.stall = 1'b0; bus.npc_selD = 2'b00; bus.br_takenD = 1'b0;
        bus.imm16D = 16'h0; bus.idx26D = 26'h0; bus.rsdataD = 32'h0;
        @(negedge clk);

        reset_and_run3();
        step("br_taken", 0, 0, 2'b01, 1, 16'hFFFF, 26'h0, 32'h0,
             32'h3008, 32'h300C, 32'hAB00300C, 32'h3014, 0);

        reset_and_run3();
        step("br_not_taken", 0, 0, 2'b01, 0, 16'hFFFF, 26'h0, 32'h0,
             32'h3010, 32'h300C, 32'hAB00300C, 32'h3014, 0);
        step("seq_to_j", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3014, 32'h3010, 32'hAB003010, 32'h3018, 0);
        step("jump", 0, 0, 2'b10, 0, 16'h0, 26'h0000C10, 32'h0,
             32'h3040, 32'h3014, 32'hAB003014, 32'h301C, 0);
        step("jtarget", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3044, 32'h3040, 32'hAB003040, 32'h3048, 0);
        step("jr_misalign", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3002,
             32'h3002, 32'h3044, 32'hAB003044, 32'h304C, 1);
        step("err_nop", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3006, 32'h3002, 32'h0, 32'h300A, 1);
        step("err_seq", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h300A, 32'h3006, 32'h0, 32'h300E, 1);
        step("jr_recover", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3020,
             32'h3020, 32'h300A, 32'h0, 32'h3012, 0);
        step("jr_in_d", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h3024, 32'h3020, 32'hAB003020, 32'h3028, 0);
        step("stall1", 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3100,
             32'h3024, 32'h3020, 32'hAB003020, 32'h3028, 0);
        step("stall2", 0, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3200,
             32'h3024, 32'h3020, 32'hAB003020, 32'h3028, 0);
        step("stall_release", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h3200,
             32'h3200, 32'h3024, 32'hAB003024, 32'h302C, 0);
        step("reset_over_stall", 1, 1, 2'b11, 0, 16'h0, 26'h0, 32'h3300,
             32'h3000, 32'h0, 32'h0, 32'h8, 0);
        step("jr_top", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'hFFFFFFFC,
             32'hFFFFFFFC, 32'h3000, 32'hAB003000, 32'h3008, 1);
        step("wrap", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h0, 32'hFFFFFFFC, 32'h0, 32'h4, 1);
        step("jr_last_word", 0, 0, 2'b11, 0, 16'h0, 26'h0, 32'h6FFC,
             32'h6FFC, 32'h0, 32'h0, 32'h8, 0);
        step("past_rom", 0, 0, 2'b00, 0, 16'h0, 26'h0, 32'h0,
             32'h7000, 32'h6FFC, 32'hAB006FFC, 32'h7004, 1);

        // Let the monitor drain; anything left over is a missed comparison.
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Fetch-stage program counter plus F/D pipeline register for the P5 five-stage MIPS core.
- Drives pcF into the instruction ROM, captures the returned instrF, and presents pcD/instrD/pc8D to the decode stage.
- Computes the next PC from decode-stage redirect information (beq-class branch, j/jal, jr) using delay-slot semantics.
- Honours the hazard-unit stall.

Parameters:
- RESET_PC, 32'h00003000, address of the first instruction; the ROM base.
- IM_WORDS, 4096, ROM depth in words; defines the legal fetch window.

Ports:
- clk  in  1  single system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- stall  in  1  from hazard unit; freezes PC and F/D register.
- instrF  in  32  instruction word returned by ROM for pcF.
- npc_selD  in  2  redirect kind for the instruction in D: 00 seq, 01 branch, 10 j/jal, 11 jr.
- br_takenD  in  1  branch comparison result in D; only meaningful when npc_selD=01.
- imm16D  in  16  branch offset field of instrD.
- idx26D  in  26  jump index field of instrD.
- rsdataD  in  32  forwarded GPR[rs] value for jr.
- pcF  out  32  current fetch address.
- addr_errF  out  1  pcF is misaligned or outside the ROM window.
- pcD  out  32  PC of the instruction held in D.
- instrD  out  32  instruction held in D.
- pc8D  out  32  pcD+8; link value for jal.

Behaviour:
- Reset, checked on a clk edge with reset=1:
  - pcF <= RESET_PC, pcD <= 0, instrD <= 0 (nop).
  - Reset has priority over stall.
  - Reset mid-operation discards any pending redirect.
- Next-PC selection, combinational from current registers:
  - seq: pcF+4.
  - branch taken: pcD+4+(sext(imm16D)<<2).
  - branch not taken: pcF+4.
  - j/jal: {pcD[31:28], idx26D, 2'b00}.
  - jr: rsdataD.
- Delay slot:
  - When D holds the branch/jump, F is already fetching pcD+4 (the delay slot).
  - That instruction is never squashed; the redirect target is loaded into pcF on the same edge the delay slot enters D.
  - Redirect latency is 1 cycle from the edge where the branch entered D. There is no flush path.
- Arithmetic:
  - All adds are 32-bit, modulo 2^32; pcF=32'hFFFFFFFC seq wraps to 0.
  - The offset is sign-extended before the shift, so imm16D=16'hFFFF means -4 bytes.
- Normal edge (stall=0, reset=0): pcF <= npc, pcD <= pcF, instrD <= (addr_errF ? 0 : instrF).
- Stall edge (stall=1):
  - pcF, pcD and instrD hold.
  - The redirect inputs are ignored: the D instruction does not advance and is re-evaluated the next cycle with fresh forwarded data.
- addr_errF is combinational.
  - It is set when pcF[1:0]!=0, pcF<RESET_PC, or pcF>=RESET_PC+4*IM_WORDS.
  - An erroring fetch enters D as nop (32'h0). pcD still records the bad pcF for later exception support.
  - The PC keeps advancing sequentially from the bad address unless redirected.
- pc8D = pcD+8, combinational, modulo 2^32.
- No output depends combinationally on instrF except through the registered instrD.

Decomposition:
- Shared package cpu_defs:
  - NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11.
  - RESET_PC constant.
  - NOP=32'h0.
- One natural sub-module: npc_calc. It is combinational; it takes pcF, pcD and the redirect fields and produces npc.
- The registers and addr_errF stay in fetch_pc_unit.

Test Plan:
- Reset then 3 free-running cycles, npc_selD=00:
  - pcF sequence is 3000, 3004, 3008, 300C.
  - pcD lags pcF by one cycle.
  - instrD equals the instrF presented the previous cycle.
- Taken branch with pcD=3008, pcF=300C, npc_selD=01, br_takenD=1, imm16D=FFFF:
  - next pcF is 3008 (loop on itself).
  - next pcD is 300C (the delay slot).
- Branch not taken under the same conditions but br_takenD=0 -> next pcF is 3010.
- j with pcD=3010, idx26D=26'h0000C10 -> next pcF is 3040; pc8D=3018 while the jal sits in D.
- jr with rsdataD=3002:
  - addr_errF=1 the next cycle.
  - instrD=0 the cycle after, with pcD=3002.
  - Following pcF is 3006.
- Stall held 2 cycles while D holds a jump, rsdataD changing 3100->3200 -> pcF, pcD and instrD are frozen:
  - pcF/pcD/instrD unchanged for both stall cycles.
  - After release, pcF=3200 (uses the latest rsdataD).
  - Assert reset together with stall -> pcF=3000, instrD=0 on that edge.
